// File: rtl/loader_pkg.sv
// Shared types and helpers for the serial program loader.
package loader_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned MAX_BYTES = 16;
    localparam int unsigned MAX_W     = BYTE_W * MAX_BYTES;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // All-ones marker covering the low nbytes bytes; callers truncate to their word width.
    function automatic logic [MAX_W-1:0] default_end_marker(input int unsigned nbytes);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < BYTE_W * nbytes) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Drops byte b into lane idx of a word of nbytes bytes; lane 0 is the LSB when little.
    function automatic logic [MAX_W-1:0] place_byte(input logic [MAX_W-1:0]  word,
                                                    input logic [BYTE_W-1:0] b,
                                                    input int unsigned       idx,
                                                    input int unsigned       nbytes,
                                                    input logic              little);
        logic [MAX_W-1:0] r;
        int unsigned      pos;
        pos = little ? idx : (nbytes - 1 - idx);
        r   = word;
        r[BYTE_W*pos +: BYTE_W] = b;
        return r;
    endfunction

endpackage

// File: rtl/serial_program_loader_if.sv
// Byte-stream, instruction-memory and pass-through signals of the loader.
interface serial_program_loader_if #(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned ADDR_W         = 14
);
    import loader_pkg::*;

    localparam int unsigned W = BYTE_W * BYTES_PER_WORD;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              restart;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [W-1:0]      imem_wdata;
    logic              load_done;
    logic [ADDR_W:0]   word_count;
    logic              overflow;
    logic              timeout_err;
    logic [BYTE_W-1:0] pass_data;
    logic              pass_valid;

    // Drives the byte stream and observes the loader.
    modport master (
        output rx_data, rx_valid, restart,
        input  imem_we, imem_addr, imem_wdata, load_done, word_count,
        input  overflow, timeout_err, pass_data, pass_valid
    );

    // The loader itself.
    modport slave (
        input  rx_data, rx_valid, restart,
        output imem_we, imem_addr, imem_wdata, load_done, word_count,
        output overflow, timeout_err, pass_data, pass_valid
    );

endinterface

// File: rtl/word_assembler.sv
// Collects bytes into words and discards stale partial words after an idle timeout.
module word_assembler
    import loader_pkg::*;
#(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter bit          LITTLE_ENDIAN  = 1'b0,
    parameter int unsigned TIMEOUT        = 0
) (
    input  logic                             CLK,
    input  logic                             XRST,
    input  logic                             enable,
    input  logic                             clear,
    input  logic [BYTE_W-1:0]                rx_data,
    input  logic                             rx_valid,
    output logic                             word_valid,
    output logic [BYTE_W*BYTES_PER_WORD-1:0] word,
    output logic                             timeout_pulse
);

    localparam int unsigned W     = BYTE_W * BYTES_PER_WORD;
    localparam int unsigned IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
    // Fires on the TIMEOUT-th idle cycle, i.e. when the count already equals TIMEOUT-1.
    localparam logic [CNT_W-1:0] FIRE_CNT = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [W-1:0]     shift_q, shift_d, placed;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic             accept, last_byte, idle_tick;

    assign accept    = enable && !clear && rx_valid;
    assign last_byte = (byte_idx_q == LAST_IDX);
    assign idle_tick = (TIMEOUT != 0) && enable && !clear && !rx_valid && (byte_idx_q != '0);
    assign placed    = W'(place_byte(MAX_W'(shift_q), rx_data, 32'(byte_idx_q),
                                     BYTES_PER_WORD, LITTLE_ENDIAN));

    assign word_valid = accept && last_byte;
    assign word       = placed;

    // Next byte position, shift contents and idle count.
    always_comb begin
        shift_d       = shift_q;
        byte_idx_d    = byte_idx_q;
        idle_d        = idle_q;
        timeout_pulse = 1'b0;
        if (clear) begin
            shift_d    = '0;
            byte_idx_d = '0;
            idle_d     = '0;
        end else if (accept) begin
            shift_d    = placed;
            byte_idx_d = last_byte ? '0 : byte_idx_q + 1'b1;
            idle_d     = '0;
        end else if (idle_tick) begin
            if (idle_q == FIRE_CNT) begin
                timeout_pulse = 1'b1;
                shift_d       = '0;
                byte_idx_d    = '0;
                idle_d        = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    // Assembly state registers.
    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            shift_q    <= '0;
            byte_idx_q <= '0;
            idle_q     <= '0;
        end else begin
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            idle_q     <= idle_d;
        end
    end

endmodule

// File: rtl/serial_program_loader.sv
// Boot loader: writes received words to instruction memory until an end marker, then
// forwards every later byte to the CPU input path.
module serial_program_loader
    import loader_pkg::*;
#(
    parameter int unsigned                      BYTES_PER_WORD = 4,
    parameter int unsigned                      ADDR_W         = 14,
    parameter logic [BYTE_W*BYTES_PER_WORD-1:0] END_MARKER     =
        (BYTE_W * BYTES_PER_WORD)'(default_end_marker(BYTES_PER_WORD)),
    parameter bit                               LITTLE_ENDIAN  = 1'b0,
    parameter int unsigned                      TIMEOUT        = 0
) (
    input logic                    CLK,
    input logic                    XRST,
    serial_program_loader_if.slave bus
);

    localparam int unsigned W = BYTE_W * BYTES_PER_WORD;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              overflow_q, overflow_d;
    logic              timeout_err_q, timeout_err_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [W-1:0]      imem_wdata_q, imem_wdata_d;
    logic              pass_valid_q, pass_valid_d;
    logic [BYTE_W-1:0] pass_data_q, pass_data_d;

    logic         word_valid;
    logic [W-1:0] word;
    logic         timeout_pulse;

    word_assembler #(
        .BYTES_PER_WORD (BYTES_PER_WORD),
        .LITTLE_ENDIAN  (LITTLE_ENDIAN),
        .TIMEOUT        (TIMEOUT)
    ) u_word_assembler (
        .CLK           (CLK),
        .XRST          (XRST),
        .enable        (state_q == ST_LOAD),
        .clear         (bus.restart),
        .rx_data       (bus.rx_data),
        .rx_valid      (bus.rx_valid),
        .word_valid    (word_valid),
        .word          (word),
        .timeout_pulse (timeout_pulse)
    );

    // Next state, write decision and pass-through; restart overrides everything.
    always_comb begin
        state_d       = state_q;
        word_count_d  = word_count_q;
        overflow_d    = overflow_q;
        timeout_err_d = timeout_err_q;
        imem_we_d     = 1'b0;
        imem_addr_d   = imem_addr_q;
        imem_wdata_d  = imem_wdata_q;
        pass_valid_d  = 1'b0;
        pass_data_d   = pass_data_q;
        if (bus.restart) begin
            state_d       = ST_LOAD;
            word_count_d  = '0;
            overflow_d    = 1'b0;
            timeout_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (word_valid) begin
                        if (word == END_MARKER) begin
                            state_d = ST_RUN;
                        end else if (!word_count_q[ADDR_W]) begin
                            // Top bit clear means word_count < DEPTH.
                            imem_we_d    = 1'b1;
                            imem_addr_d  = word_count_q[ADDR_W-1:0];
                            imem_wdata_d = word;
                            word_count_d = word_count_q + 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    if (timeout_pulse) begin
                        timeout_err_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.rx_valid) begin
                        pass_valid_d = 1'b1;
                        pass_data_d  = bus.rx_data;
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            state_q       <= ST_LOAD;
            word_count_q  <= '0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            imem_we_q     <= 1'b0;
            imem_addr_q   <= '0;
            imem_wdata_q  <= '0;
            pass_valid_q  <= 1'b0;
            pass_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            word_count_q  <= word_count_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
            imem_we_q     <= imem_we_d;
            imem_addr_q   <= imem_addr_d;
            imem_wdata_q  <= imem_wdata_d;
            pass_valid_q  <= pass_valid_d;
            pass_data_q   <= pass_data_d;
        end
    end

    assign bus.imem_we     = imem_we_q;
    assign bus.imem_addr   = imem_addr_q;
    assign bus.imem_wdata  = imem_wdata_q;
    assign bus.load_done   = (state_q == ST_RUN);
    assign bus.word_count  = word_count_q;
    assign bus.overflow    = overflow_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.pass_data   = pass_data_q;
    assign bus.pass_valid  = pass_valid_q;

endmodule
